fetch_decode: RTL and testbench



---
 rtl/fetch_decode_if.sv | 35 +++
 rtl/fetch_decode.sv | 110 +++++++++++
 tb/tb_fetch_decode.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// Bus between the fetch/decode sequencer and its host, instruction ROM, branch LUT and ALU.
// The slave modport is the sequencer's view; the master modport is the environment's.
interface fetch_decode_if #(
    parameter int unsigned PC_W = 10,
    parameter int unsigned IW   = 9
);
    logic            start;
    logic            done;
    logic [PC_W-1:0] inst_addr;
    logic [IW-1:0]   instr;
    logic [2:0]      aluop;
    logic [1:0]      funct;
    logic [3:0]      immed;
    logic [1:0]      raddr_a;
    logic [1:0]      raddr_b;
    logic [1:0]      wr_addr;
    logic            wr_en;
    logic [1:0]      lut_idx;
    logic [PC_W-1:0] lut_tgt;
    logic            jen;
    logic            alu_done;
    logic [15:0]     inst_cnt;

    modport master (
        output start, instr, lut_tgt, jen, alu_done,
        input  done, inst_addr, aluop, funct, immed, raddr_a, raddr_b,
               wr_addr, wr_en, lut_idx, inst_cnt
    );

    modport slave (
        input  start, instr, lut_tgt, jen, alu_done,
        output done, inst_addr, aluop, funct, immed, raddr_a, raddr_b,
               wr_addr, wr_en, lut_idx, inst_cnt
    );
endinterface

// File: rtl/fetch_decode.sv
// Two-cycle fetch/execute sequencer: latches an instruction into IR, then decodes it in EXEC.
// Start arms the block; its falling edge launches the program from address 0.
module fetch_decode #(
    parameter int unsigned PC_W = 10,
    parameter int unsigned IW   = 9   // only 9 is supported
) (
    input logic           clk,
    input logic           rst,
    fetch_decode_if.slave bus_io
);

    typedef enum logic [2:0] {StIdle, StArm, StFetch, StExec, StHalt} state_e;

    localparam logic [IW-1:0] NopInstr = IW'(9'h100);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      op;
    logic            restart;

    assign op = ir_q[8:6];

    // Start while running or halted aborts back to ARM.
    assign restart = bus_io.start &&
                     ((state_q == StFetch) || (state_q == StExec) || (state_q == StHalt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= NopInstr;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus_io.start) state_d = StArm;
            end
            StArm: begin
                pc_d  = '0;
                cnt_d = '0;
                if (!bus_io.start) state_d = StFetch;
            end
            StFetch: begin
                ir_d    = bus_io.instr;
                state_d = StExec;
            end
            StExec: begin
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                if ((op == 3'b111) || bus_io.alu_done) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                    if (((op == 3'b101) || (op == 3'b110)) && bus_io.jen) begin
                        pc_d = bus_io.lut_tgt;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (restart) begin
            state_d = StArm;
            pc_d    = '0;
            cnt_d   = '0;
            ir_d    = ir_q;
        end
    end

    always_comb begin
        bus_io.done      = (state_q == StHalt);
        bus_io.inst_addr = pc_q;
        bus_io.inst_cnt  = cnt_q;
        bus_io.raddr_a   = ir_q[3:2];
        bus_io.raddr_b   = ir_q[1:0];
        bus_io.lut_idx   = ir_q[5:4];
        bus_io.wr_addr   = (op == 3'b010) ? ir_q[5:4] : ir_q[3:2];
        bus_io.aluop     = 3'b100;
        bus_io.funct     = 2'b00;
        bus_io.immed     = 4'h0;
        bus_io.wr_en     = 1'b0;
        if (state_q == StExec) begin
            bus_io.aluop = op;
            bus_io.funct = ir_q[5:4];
            bus_io.immed = ir_q[3:0];
            // An aborting Start must not let the pending write through.
            bus_io.wr_en = ~op[2] & ~bus_io.start;
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: an instruction-level model predicts writes and halt state into
// queues; a negedge monitor pops and compares them as the DUT produces them.
module tb_fetch_decode;
    localparam int unsigned PC_W  = 10;
    localparam int unsigned DEPTH = 1 << PC_W;
    localparam logic [8:0]  HALT_I = 9'h1C0;
    localparam logic [8:0]  NOP_I  = 9'h100;

    logic clk = 1'b0;
    logic rst;

    fetch_decode_if #(.PC_W(PC_W), .IW(9)) bus ();
    fetch_decode #(.PC_W(PC_W), .IW(9)) dut (.clk(clk), .rst(rst), .bus_io(bus));

    always #5 clk = ~clk;

    logic [8:0]      rom     [DEPTH];
    logic [PC_W-1:0] lut     [4];
    bit              jen_tbl [DEPTH];
    bit              ad_tbl  [DEPTH];

    assign bus.instr    = rom[bus.inst_addr];
    assign bus.lut_tgt  = lut[bus.lut_idx];
    assign bus.jen      = jen_tbl[bus.inst_addr];
    assign bus.alu_done = ad_tbl[bus.inst_addr];

    int tests = 0;
    int fails = 0;
    logic [10:0] wq[$];  // {wr_addr, immed, funct, aluop}
    logic [25:0] fq[$];  // {inst_cnt, pc}

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        tests++;
        fails++;
        $display("FAIL %s: got unexpected/late event, expected none", name);
    endtask

    function automatic logic [10:0] exp_write(logic [8:0] ins);
        logic [1:0] wa;
        wa = (ins[8:6] == 3'd2) ? ins[5:4] : ins[3:2];
        return {wa, ins[3:0], ins[5:4], ins[8:6]};
    endfunction

    // Executes the ROM one instruction at a time; queues results only if the program halts.
    task automatic model(output bit ok, output int n);
        logic [PC_W-1:0] pc;
        logic [15:0]     cnt;
        logic [8:0]      ins;
        logic [2:0]      op;
        logic [10:0]     wl[$];
        pc = '0; cnt = '0; ok = 1'b0; n = 0;
        for (int s = 0; s < 200; s++) begin
            ins = rom[pc];
            op  = ins[8:6];
            if (op < 3'd4) wl.push_back(exp_write(ins));
            if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
            n++;
            if (op == 3'd7 || ad_tbl[pc]) begin
                ok = 1'b1;
                break;
            end
            if ((op == 3'd5 || op == 3'd6) && jen_tbl[pc]) pc = lut[ins[5:4]];
            else pc = pc + PC_W'(1);
        end
        if (ok) begin
            foreach (wl[i]) wq.push_back(wl[i]);
            fq.push_back({cnt, pc});
        end
    endtask

    task automatic clear_tables(logic [8:0] fill);
        for (int a = 0; a < DEPTH; a++) begin
            rom[a] = fill; jen_tbl[a] = 1'b0; ad_tbl[a] = 1'b0;
        end
        for (int k = 0; k < 4; k++) lut[k] = '0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic launch(string name, int n);
        int cyc;
        pulse_start();
        cyc = 0;
        while (!bus.done && cyc < 2 * n + 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.done) fail_now({name, "_halt_timeout"});
        @(posedge clk); #1;
    endtask

    task automatic run_directed(string name);
        bit ok; int n;
        model(ok, n);
        if (!ok) fail_now({name, "_model_no_halt"});
        else launch(name, n);
    endtask

    initial begin : monitor
        logic        done_prev;
        logic [10:0] w;
        logic [25:0] f;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (bus.wr_en) begin
                    if (wq.size() == 0) fail_now("unexpected_write");
                    else begin
                        w = wq.pop_front();
                        check("write", {bus.wr_addr, bus.immed, bus.funct, bus.aluop}, w);
                    end
                end
                if (bus.done && !done_prev) begin
                    if (fq.size() == 0) fail_now("unexpected_done");
                    else begin
                        f = fq.pop_front();
                        check("halt_inst_cnt", bus.inst_cnt, f[25:10]);
                        check("halt_pc", bus.inst_addr, f[9:0]);
                        check("writes_drained", wq.size(), 0);
                    end
                end
                done_prev = bus.done;
            end
        end
    end

    initial begin : stim
        int cyc;
        bit ok;
        int n;
        rst = 1'b1;
        bus.start = 1'b0;
        clear_tables(HALT_I);
        #1;
        check("rst_done", bus.done, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_inst_cnt", bus.inst_cnt, 0);
        check("rst_inst_addr", bus.inst_addr, 0);
        check("rst_aluop", bus.aluop, 3'b100);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("idle_held_done", bus.done, 0);
        check("idle_held_cnt", bus.inst_cnt, 0);

        // mov then halt
        clear_tables(HALT_I);
        rom[0] = 9'b010_01_0101;
        run_directed("mov_halt");

        // beq taken / not taken
        clear_tables(HALT_I);
        rom[0] = 9'b101_10_0001; lut[2] = PC_W'(40); jen_tbl[0] = 1'b1;
        run_directed("beq_taken");
        jen_tbl[0] = 1'b0;
        run_directed("beq_not_taken");

        // Halted program stays halted with Start low
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check("halt_hold_done", bus.done, 1);
            check("halt_hold_wr_en", bus.wr_en, 0);
            check("halt_hold_cnt", bus.inst_cnt, 2);
        end

        // PC wrap through 1023 with nops only
        clear_tables(NOP_I);
        pulse_start();
        cyc = 0;
        while (bus.inst_addr != 10'd1023 && cyc < 2100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (bus.inst_addr != 10'd1023) fail_now("wrap_reach_timeout");
        @(posedge clk); #1;
        check("wrap_exec_addr", bus.inst_addr, 10'd1023);
        @(posedge clk); #1;
        check("wrap_addr", bus.inst_addr, 0);
        check("wrap_done", bus.done, 0);
        check("wrap_cnt", bus.inst_cnt, 1024);
        pulse_start();
        #1 check("wrap_abort_cnt", bus.inst_cnt, 0);

        // Start raised during EXEC of the 3rd instruction
        clear_tables(HALT_I);
        for (int a = 0; a < 5; a++) rom[a] = {3'($urandom_range(0, 3)), 6'($urandom)};
        wq.push_back(exp_write(rom[0]));
        wq.push_back(exp_write(rom[1]));
        pulse_start();
        cyc = 0;
        while (bus.inst_cnt != 16'd2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        check("abort_pre_wr_en", bus.wr_en, 1);
        bus.start = 1'b1;
        #1 check("abort_wr_en", bus.wr_en, 0);
        @(posedge clk); #1;
        check("abort_addr", bus.inst_addr, 0);
        check("abort_cnt", bus.inst_cnt, 0);
        check("abort_done", bus.done, 0);
        run_directed("abort_restart");

        // Reset mid-FETCH
        wq.push_back(exp_write(rom[0]));
        wq.push_back(exp_write(rom[1]));
        pulse_start();
        cyc = 0;
        while (bus.inst_cnt != 16'd2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("prereset_addr", bus.inst_addr, 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_addr", bus.inst_addr, 0);
        check("async_rst_cnt", bus.inst_cnt, 0);
        check("async_rst_wr_en", bus.wr_en, 0);
        check("async_rst_done", bus.done, 0);
        check("async_rst_aluop", bus.aluop, 3'b100);
        wq.delete();
        fq.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("post_rst_idle_cnt", bus.inst_cnt, 0);
        run_directed("reset_restart");

        // Random programs
        for (int t = 0; t < 12; t++) begin
            ok = 1'b0;
            while (!ok) begin
                clear_tables(HALT_I);
                for (int a = 0; a < 32; a++) begin
                    rom[a]     = 9'($urandom);
                    jen_tbl[a] = 1'($urandom);
                    ad_tbl[a]  = ($urandom_range(0, 15) == 0);
                end
                for (int k = 0; k < 4; k++) lut[k] = PC_W'($urandom_range(0, 40));
                model(ok, n);
            end
            launch("random", n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
